// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the register-read stage and the multicycle ALU.
// The master side issues operations and consumes results; the ALU is the slave.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             zero_flag;
    logic             negative_flag;
    logic             carry_flag;
    logic             overflow_flag;
    logic             illegal_op;

    modport master (
        output in_valid, alu_control, data1, data2, out_ready,
        input  in_ready, out_valid, alu_result, zero_flag, negative_flag,
               carry_flag, overflow_flag, illegal_op
    );

    modport slave (
        input  in_valid, alu_control, data1, data2, out_ready,
        output in_ready, out_valid, alu_result, zero_flag, negative_flag,
               carry_flag, overflow_flag, illegal_op
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle ops finish in one edge,
// MUL iterates one shift-add step per edge and stalls the front end meanwhile.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_alu_if.slave      bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] MUL  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_CBNZ = 4'b1111;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_ORR  = 4'b0100;
    localparam logic [3:0] OP_EOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    logic [1:0]         state_q;
    logic [WIDTH-1:0]   result_q;
    logic               z_q, n_q, c_q, v_q, ill_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHAMT_W-1:0] cnt_q;

    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     sum, diff;
    logic               z, n, c, v, ill;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = bus.data2[SHAMT_W-1:0];
    assign sum   = {1'b0, bus.data1} + {1'b0, bus.data2};
    // Carry out of A + ~B + 1 is the "no borrow" indication.
    assign diff  = {1'b0, bus.data1} + {1'b0, ~bus.data2} + (WIDTH+1)'(1);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        unique case (bus.alu_control)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) && (res[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) && (res[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            OP_CBZ, OP_CBNZ: res = bus.data2;
            OP_AND:  res = bus.data1 & bus.data2;
            OP_ORR:  res = bus.data1 | bus.data2;
            OP_EOR:  res = bus.data1 ^ bus.data2;
            OP_NOR:  res = ~(bus.data1 | bus.data2);
            OP_NAND: res = ~(bus.data1 & bus.data2);
            OP_MOV:  res = bus.data1;
            OP_LSL:  res = bus.data1 << shamt;
            OP_LSR:  res = bus.data1 >> shamt;
            OP_MUL:  res = '0;
            default: ill = 1'b1;
        endcase
        // Branch opcodes redefine the zero flag as their test on operand B.
        if (bus.alu_control == OP_CBZ)       z = (bus.data2 == '0);
        else if (bus.alu_control == OP_CBNZ) z = (bus.data2 != '0);
        else                                 z = (res == '0);
        n = res[WIDTH-1];
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    if (bus.alu_control == OP_MUL) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.data1};
                        mplier_q <= bus.data2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end else begin
                        result_q <= res;
                        z_q      <= z;
                        n_q      <= n;
                        c_q      <= c;
                        v_q      <= v;
                        ill_q    <= ill;
                        state_q  <= DONE;
                    end
                end
                MUL: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(WIDTH-1)) begin
                        result_q <= acc_step[WIDTH-1:0];
                        z_q      <= (acc_step[WIDTH-1:0] == '0);
                        n_q      <= acc_step[WIDTH-1];
                        c_q      <= 1'b0;
                        v_q      <= |acc_step[2*WIDTH-1:WIDTH];
                        ill_q    <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.alu_result    = result_q;
    assign bus.zero_flag     = z_q;
    assign bus.negative_flag = n_q;
    assign bus.carry_flag    = c_q;
    assign bus.overflow_flag = v_q;
    assign bus.illegal_op    = ill_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: a reference model pushes expected results
// when an op is issued; they are popped and compared when the ALU presents output.
module tb_multicycle_alu;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic z, n, c, v, ill;
        logic [3:0] op;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(W)) bus ();
    multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        e.op = op; e.res = '0; e.c = 0; e.v = 0; e.ill = 0;
        case (op)
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0]; e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b1010: begin
                e.res = a - b; e.c = (a >= b);
                e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0111, 4'b1111: e.res = b;
            4'b0110: e.res = a & b;
            4'b0100: e.res = a | b;
            4'b1001: e.res = a ^ b;
            4'b0101: e.res = ~(a | b);
            4'b1100: e.res = ~(a & b);
            4'b1101: e.res = a;
            4'b0011: e.res = a << b[4:0];
            4'b1011: e.res = a >> b[4:0];
            4'b1000: begin
                p = 64'(a) * 64'(b);
                e.res = p[W-1:0]; e.v = (p[2*W-1:W] != 0);
            end
            default: e.ill = 1;
        endcase
        if (op == 4'b0111)      e.z = (b == 0);
        else if (op == 4'b1111) e.z = (b != 0);
        else                    e.z = (e.res == 0);
        e.n = e.ill ? 1'b0 : e.res[W-1];
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_res"}, 64'(bus.alu_result), 64'(e.res));
        check({tag, "_z"}, 64'(bus.zero_flag), 64'(e.z));
        check({tag, "_n"}, 64'(bus.negative_flag), 64'(e.n));
        check({tag, "_c"}, 64'(bus.carry_flag), 64'(e.c));
        check({tag, "_v"}, 64'(bus.overflow_flag), 64'(e.v));
        check({tag, "_ill"}, 64'(bus.illegal_op), 64'(e.ill));
    endtask

    // Issue one op, measure latency, hold out_ready low for 'hold' cycles, then retire it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        int lat;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_control = op; bus.data1 = a; bus.data2 = b;
        sb.push_back(model(op, a, b));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.alu_control = 4'($urandom); bus.data1 = $urandom; bus.data2 = $urandom;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin
            check({tag, "_busy_in_ready"}, 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(lat), (op == 4'b1000) ? 64'(W + 1) : 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            for (int h = 0; h <= hold; h++) begin
                check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
                check({tag, "_done_in_ready"}, 64'(bus.in_ready), 64'd0);
                check_outputs(tag, e);
                if (h < hold) @(negedge clk);
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            check({tag, "_retired_valid"}, 64'(bus.out_valid), 64'd0);
            check({tag, "_retired_in_ready"}, 64'(bus.in_ready), 64'd1);
            check({tag, "_held_res"}, 64'(bus.alu_result), 64'(e.res));
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.alu_control = '0; bus.data1 = '0; bus.data2 = '0;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_res", 64'(bus.alu_result), 64'd0);
        check("rst_flags", 64'({bus.zero_flag, bus.negative_flag, bus.carry_flag,
                               bus.overflow_flag, bus.illegal_op}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("add_cry",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_eq",   4'b1010, 32'h0000_0005, 32'h0000_0005, 3);
        run_op("sub_brw",  4'b1010, 32'h0000_0003, 32'h0000_0005, 0);
        run_op("sub_vov",  4'b1010, 32'h8000_0000, 32'h0000_0001, 0);
        run_op("mul_ovf",  4'b1000, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("mul_7x6",  4'b1000, 32'd7,         32'd6,         1);
        run_op("mul_max",  4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("lsl",      4'b0011, 32'h0000_0001, 32'h0000_0025, 0);
        run_op("lsr",      4'b1011, 32'h8000_0000, 32'd31,        0);
        run_op("lsr_hib",  4'b1011, 32'hF000_0000, 32'hFFFF_FFE4, 0);
        run_op("cbz0",     4'b0111, 32'h1234_5678, 32'h0000_0000, 0);
        run_op("cbnz0",    4'b1111, 32'h1234_5678, 32'h0000_0000, 0);
        run_op("cbnz1",    4'b1111, 32'h0,         32'h8000_0000, 0);
        run_op("and",      4'b0110, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run_op("orr",      4'b0100, 32'hF000_0001, 32'h0000_0F10, 0);
        run_op("eor",      4'b1001, 32'hAAAA_5555, 32'hFFFF_FFFF, 0);
        run_op("nor",      4'b0101, 32'h0000_0000, 32'h0000_0000, 0);
        run_op("nand",     4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mov",      4'b1101, 32'h8765_4321, 32'h1111_1111, 0);
        run_op("illegal",  4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Abort a multiply with an asynchronous reset pulse mid-iteration.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_control = 4'b1000;
        bus.data1 = 32'hDEAD_BEEF; bus.data2 = 32'h1234_5678;
        sb.push_back(model(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_res", 64'(bus.alu_result), 64'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
